// File: rtl/wb_pkg.sv
// Shared encodings for the writeback unit: result-source selects, load
// funct3 codes and FSM states.
package wb_pkg;

    typedef enum logic [2:0] {
        WB_ALU   = 3'b000,
        WB_LOAD  = 3'b001,
        WB_LINK  = 3'b010,
        WB_LUI   = 3'b011,
        WB_AUIPC = 3'b100
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a raw load word and sign- or
// zero-extends it to XLEN; unknown size codes behave as a full word.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: picks the result source, waits for load data when needed,
// and drives a registered one-cycle register-file write pulse.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      wb_sel,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall
);

    wb_state_e       state;
    logic [RA_W-1:0] cap_rd;
    logic [2:0]      cap_funct3;
    logic [1:0]      cap_off;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] direct_data;
    logic            direct_write;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3 (cap_funct3),
        .off    (cap_off),
        .rdata  (mem_rdata),
        .data   (load_data)
    );

    always_comb begin
        direct_data  = alu_result;
        direct_write = 1'b1;
        case (wb_sel_e'(wb_sel))
            WB_ALU:   direct_data = alu_result;
            WB_LINK:  direct_data = pc + XLEN'(4);
            WB_LUI:   direct_data = imm;
            WB_AUIPC: direct_data = pc + imm;
            default:  direct_write = 1'b0;
        endcase
    end

    assign in_ready = (state == S_IDLE);
    assign stall    = (state == S_WAIT_MEM);

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            cap_rd     <= '0;
            cap_funct3 <= '0;
            cap_off    <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (wb_sel_e'(wb_sel) == WB_LOAD) begin
                            cap_rd     <= rd_addr;
                            cap_funct3 <= ld_funct3;
                            cap_off    <= ld_off;
                            state      <= S_WAIT_MEM;
                        end else if (direct_write && rd_addr != '0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rd_addr;
                            rf_wdata <= direct_data;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        // x0 destinations still complete the load, just without a write.
                        if (cap_rd != '0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= cap_rd;
                            rf_wdata <= load_data;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued when
// stimulus is driven and compared whenever the unit pulses rf_we.
module tb_writeback_unit;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      wb_sel;
    logic [RA_W-1:0] rd_addr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_off;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rf_we;
    logic [RA_W-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            stall;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t sb[$];

    writeback_unit #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_sel     (wb_sel),
        .rd_addr    (rd_addr),
        .alu_result (alu_result),
        .pc         (pc),
        .imm        (imm),
        .ld_funct3  (ld_funct3),
        .ld_off     (ld_off),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference load model, written as shift-and-mask on the raw word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sb_w;
        logic [31:0] sh_w;
        sb_w = w >> (off * 8);
        sh_w = w >> (off[1] * 16);
        case (f3)
            3'b000:  ref_load = sb_w[7]  ? (sb_w | 32'hFFFF_FF00) : (sb_w & 32'h0000_00FF);
            3'b001:  ref_load = sh_w[15] ? (sh_w | 32'hFFFF_0000) : (sh_w & 32'h0000_FFFF);
            3'b100:  ref_load = sb_w & 32'h0000_00FF;
            3'b101:  ref_load = sh_w & 32'h0000_FFFF;
            default: ref_load = w;
        endcase
    endfunction

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {31'b0, rf_we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.addr});
                check("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    // Drive a one-cycle non-load request at a negedge; queue the write it should make.
    task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] exp_data,
                         input bit writes);
        check("in_ready_issue", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; wb_sel = sel; rd_addr = rd;
        alu_result = alu; pc = p; imm = im;
        if (writes && rd != 0) sb.push_back('{addr: rd, data: exp_data});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issue a load, hold off mem_rvalid for nwait stall cycles, then deliver data.
    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                           input logic [31:0] word, input int nwait, input logic [31:0] exp_data);
        in_valid = 1'b1; wb_sel = 3'b001; rd_addr = rd; ld_funct3 = f3; ld_off = off;
        @(negedge clk);
        in_valid = 1'b0; wb_sel = 3'b111; ld_funct3 = 3'b000; ld_off = 2'b00;
        for (int i = 0; i < nwait; i++) begin
            check("stall_wait", {31'b0, stall}, 32'd1);
            check("in_ready_wait", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        check("stall_last", {31'b0, stall}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = word;
        if (rd != 0) sb.push_back('{addr: rd, data: exp_data});
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        check("stall_done", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; wb_sel = 3'b000; rd_addr = '0;
        alu_result = '0; pc = '0; imm = '0; ld_funct3 = '0; ld_off = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_rf_we", {31'b0, rf_we}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_waddr", {27'b0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ALU write, then rf_we must drop next cycle (the monitor flags any extra pulse)
        issue(3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 1'b1);
        @(negedge clk);
        check("alu_we_drop", {31'b0, rf_we}, 32'd0);

        // LINK wraps modulo 2^32
        issue(3'b010, 5'd1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 1'b1);
        // LUI and AUIPC back to back
        issue(3'b011, 5'd4, 32'h0, 32'h0, 32'hABCD_E000, 32'hABCD_E000, 1'b1);
        issue(3'b100, 5'd6, 32'h0, 32'h0000_1000, 32'h1234_5000, 32'h1234_6000, 1'b1);
        @(negedge clk);

        // x0 suppression and NONE source: no writes, outputs hold last written values
        issue(3'b011, 5'd0, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 1'b0);
        issue(3'b110, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("hold_waddr", {27'b0, rf_waddr}, 32'd6);
        check("hold_wdata", rf_wdata, 32'h1234_6000);

        // mem_rvalid in IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("idle_rvalid_ready", {31'b0, in_ready}, 32'd1);

        // LB with three stall cycles, then LHU
        do_load(3'b000, 2'd2, 5'd7, 32'h0080_FF00, 2, 32'hFFFF_FF80);
        do_load(3'b101, 2'd2, 5'd8, 32'h8001_ABCD, 0, 32'h0000_8001);
        // Load to x0 completes without writing
        do_load(3'b010, 2'd0, 5'd0, 32'hCAFE_F00D, 1, 32'h0);

        // Randomised loads across all size codes and offsets
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  f3;
            logic [1:0]  off;
            logic [31:0] w;
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            w   = $urandom;
            do_load(f3, off, 5'($urandom_range(1, 31)), w, $urandom_range(0, 3), ref_load(f3, off, w));
        end

        // Reset while a load is pending: the later mem_rvalid must not write
        in_valid = 1'b1; wb_sel = 3'b001; rd_addr = 5'd9; ld_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_stall", {31'b0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_stall", {31'b0, stall}, 32'd0);
        check("async_rst_waddr", {27'b0, rf_waddr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_wdata", rf_wdata, 32'd0);
        @(negedge clk);

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter RA_W, default 5, meaning register-index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  writeback request presented this cycle.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port wb_sel  input  3  result source select.
REQ-008 SHALL have port rd_addr  input  RA_W  destination register index.
REQ-009 SHALL have port alu_result  input  XLEN  ALU output.
REQ-010 SHALL have port pc  input  XLEN  PC of the requesting instruction.
REQ-011 SHALL have port imm  input  XLEN  pre-shifted U-type immediate.
REQ-012 SHALL have port ld_funct3  input  3  load size/sign code.
REQ-013 SHALL have port ld_off  input  2  low two bits of the load address.
REQ-014 SHALL have port mem_rvalid  input  1  load data valid this cycle.
REQ-015 SHALL have port mem_rdata  input  XLEN  raw aligned load word.
REQ-016 SHALL have port rf_we  output  1  register-file write enable.
REQ-017 SHALL have port rf_waddr  output  RA_W  register-file write index.
REQ-018 SHALL have port rf_wdata  output  XLEN  register-file write data.
REQ-019 SHALL have port stall  output  1  upstream must hold; load outstanding.

Function
REQ-020 SHALL decode wb_sel: 000 ALU = alu_result; 001 LOAD; 010 LINK = pc+4; 011 LUI = imm; 100 AUIPC = pc+imm; 101-111 NONE = no write.
REQ-021 SHALL compute pc+4 and pc+imm modulo 2^XLEN, carry discarded.
REQ-022 SHALL implement FSM states IDLE and WAIT_MEM; in_ready=1 only in IDLE; stall=1 only in WAIT_MEM.
REQ-023 SHALL, in IDLE on in_valid with a non-LOAD, non-NONE source, register rf_wdata/rf_waddr and pulse rf_we for exactly the next cycle (latency 1); state stays IDLE.
REQ-024 SHALL, in IDLE on in_valid with LOAD, capture rd_addr, ld_funct3 and ld_off, move to WAIT_MEM, and produce no write.
REQ-025 SHALL, in WAIT_MEM on mem_rvalid, write the aligned/extended datum to the captured rd on the next cycle (rf_we pulse) and return to IDLE.
REQ-026 SHALL stay in WAIT_MEM indefinitely while mem_rvalid=0, holding all captured fields.
REQ-027 SHALL ignore mem_rvalid in IDLE.
REQ-028 SHALL align loads: LB/LBU select byte ld_off; LH/LHU select halfword ld_off[1]; LW ignores ld_off; LB/LH sign-extend, LBU/LHU zero-extend to XLEN.
REQ-029 SHALL treat ld_funct3 values 011, 110, 111 as LW.
REQ-030 SHALL suppress rf_we whenever the destination index is 0; state transitions are unaffected.
REQ-031 SHALL keep rf_we=0 when wb_sel is NONE or in_valid=0.
REQ-032 SHALL hold rf_waddr and rf_wdata at their last written values while rf_we=0.

Reset
REQ-033 SHALL, on rst assertion, asynchronously force state IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, and all captured load fields to 0.
REQ-034 SHALL drop any pending load on reset in WAIT_MEM; a mem_rvalid following reset release produces no write.
REQ-035 SHALL, after reset, drive in_ready=1 and stall=0.

Structure
REQ-036 SHALL place the wb_sel encodings, load funct3 codes and FSM state encodings in a shared package, wb_pkg.
REQ-037 SHALL implement alignment/extension in one combinational sub-module, load_align, instantiated once.

Verification
REQ-038 SHALL test ALU: wb_sel=000, rd=5, alu_result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234, then rf_we=0.
REQ-039 SHALL test LINK wrap: wb_sel=010, pc=0xFFFFFFFC, rd=1 -> rf_wdata=0x00000000.
REQ-040 SHALL test LB with 3-cycle wait: ld_funct3=000, ld_off=2, rd=7; mem_rdata=0x0080FF00 at cycle 3 -> stall=1 for 3 cycles, then rf_wdata=0xFFFFFF80 to x7.
REQ-041 SHALL test LHU: ld_funct3=101, ld_off=2, mem_rdata=0x8001ABCD -> rf_wdata=0x00008001.
REQ-042 SHALL test x0 suppression: wb_sel=011, rd=0, imm=0xABCDE000 -> rf_we stays 0.
REQ-043 SHALL test reset during WAIT_MEM: rst pulsed, then mem_rvalid=1 -> no write, in_ready=1.
